// File: rtl/stoch_gate_accum_if.sv
// Bundles the sample, result and window-count signals of the stochastic
// gate accumulator so the source and the datapath share one port.
interface stoch_gate_accum_if #(
  parameter int N      = 4,
  parameter int WINDOW = 256
);
  localparam int CW = $clog2(WINDOW + 1);

  logic              clear;
  logic [2:0]        op;
  logic              in_valid;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic [N-1:0]      y;
  logic              out_valid;
  logic [N*CW-1:0]   counts;
  logic              count_valid;
  logic              busy;

  modport master (
    output clear, op, in_valid, a, b,
    input  y, out_valid, counts, count_valid, busy
  );

  modport slave (
    input  clear, op, in_valid, a, b,
    output y, out_valid, counts, count_valid, busy
  );
endinterface

// File: rtl/stoch_gate_accum.sv
// N-channel stochastic-bitstream logic unit: applies one boolean op per
// channel to unipolar bitstreams, registers the result, and counts ones
// per channel over a fixed window of accepted samples.
module stoch_gate_accum #(
  parameter int N      = 4,
  parameter int WINDOW = 256
) (
  input  logic               clk,
  input  logic               rst,
  stoch_gate_accum_if.slave  bus
);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WINDOW - 1);

  logic [IW-1:0]   idx;
  logic [2:0]      op_active;
  logic [2:0]      eff_op;
  logic [N-1:0]    f;
  logic [CW-1:0]   acc     [N];
  logic [CW-1:0]   acc_sum [N];
  logic            accepted;
  logic            last;
  logic [N-1:0]    y_q;
  logic            out_valid_q;
  logic [N*CW-1:0] counts_q;
  logic            count_valid_q;

  // clear wins over in_valid, so a clear cycle never contributes a sample
  assign accepted = bus.in_valid & ~bus.clear;
  assign last     = (idx == LAST_IDX);
  // the op is taken live on the first sample of a window and held afterwards
  assign eff_op   = (idx == '0) ? bus.op : op_active;

  // per-channel boolean op selected by the effective op code
  always_comb begin
    f = bus.a & bus.b;
    case (eff_op)
      3'd0: f = bus.a & bus.b;
      3'd1: f = bus.a | bus.b;
      3'd2: f = bus.a & ~bus.b;
      3'd3: f = bus.a | ~bus.b;
      3'd4: f = bus.a ^ bus.b;
      3'd5: f = ~(bus.a ^ bus.b);
      3'd6: f = ~(bus.a & bus.b);
      3'd7: f = ~(bus.a | bus.b);
    endcase
  end

  // running count including the current sample, used for both acc and counts
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_sum[i] = acc[i] + CW'(f[i]);
    end
  end

  // output sample register: one-cycle latency, y holds when no sample is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= accepted;
      if (accepted) begin
        y_q <= f;
      end
    end
  end

  // window bookkeeping: sample index, latched op and per-channel accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      op_active <= 3'd0;
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else if (bus.clear) begin
      idx <= '0;
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else if (accepted) begin
      if (idx == '0) begin
        op_active <= bus.op;
      end
      if (last) begin
        idx <= '0;
        for (int i = 0; i < N; i++) begin
          acc[i] <= '0;
        end
      end else begin
        idx <= idx + 1'b1;
        for (int i = 0; i < N; i++) begin
          acc[i] <= acc_sum[i];
        end
      end
    end
  end

  // publish completed-window counts and pulse count_valid for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counts_q      <= '0;
      count_valid_q <= 1'b0;
    end else begin
      count_valid_q <= accepted & last;
      if (accepted && last) begin
        for (int i = 0; i < N; i++) begin
          counts_q[i*CW +: CW] <= acc_sum[i];
        end
      end
    end
  end

  assign bus.y           = y_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.counts      = counts_q;
  assign bus.count_valid = count_valid_q;
  assign bus.busy        = (idx != '0);
endmodule

// File: tb/tb_stoch_gate_accum.sv
// Directed bench for stoch_gate_accum with N=4, WINDOW=8 (CW=4).
module tb_stoch_gate_accum;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stoch_gate_accum_if #(.N(4), .WINDOW(8)) bus ();

  stoch_gate_accum #(.N(4), .WINDOW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic c, input logic [2:0] o,
                      input logic [3:0] aa, input logic [3:0] bb);
    bus.in_valid = v;
    bus.clear    = c;
    bus.op       = o;
    bus.a        = aa;
    bus.b        = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    #12;
    checks++; if (bus.y !== 4'b0) begin errors++; $display("[TB] FAIL reset_y got %b expected %b", bus.y, 4'b0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.counts !== 16'h0000) begin errors++; $display("[TB] FAIL reset_counts got %h expected 0000", bus.counts); end
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_count_valid got %b expected 0", bus.count_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_andnot();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0101);
      checks++; if (bus.y !== 4'b1010) begin errors++; $display("[TB] FAIL andnot_y[%0d] got %b expected 1010", i, bus.y); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL andnot_out_valid[%0d] got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.count_valid !== (i == 7)) begin errors++; $display("[TB] FAIL andnot_count_valid[%0d] got %b expected %b", i, bus.count_valid, (i == 7)); end
    end
    checks++; if (bus.counts !== 16'h8080) begin errors++; $display("[TB] FAIL andnot_counts got %h expected 8080", bus.counts); end
    step(1'b0, 1'b0, 3'd2, 4'b1111, 4'b0101);
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("[TB] FAIL andnot_pulse_width got %b expected 0", bus.count_valid); end
    checks++; if (bus.counts !== 16'h8080) begin errors++; $display("[TB] FAIL andnot_counts_hold got %h expected 8080", bus.counts); end
    checks++; if (bus.y !== 4'b1010) begin errors++; $display("[TB] FAIL andnot_y_hold got %b expected 1010", bus.y); end
  endtask

  // a=1100, b=1010 puts all four (a,b) pairs on channels 3..0: 11,10,01,00
  task automatic test_op_sweep();
    logic [3:0] expected [8];
    expected[0] = 4'b1000;
    expected[1] = 4'b1110;
    expected[2] = 4'b0100;
    expected[3] = 4'b1101;
    expected[4] = 4'b0110;
    expected[5] = 4'b1001;
    expected[6] = 4'b0111;
    expected[7] = 4'b0001;
    for (int o = 0; o < 8; o++) begin
      step(1'b0, 1'b1, 3'(o), 4'b0000, 4'b0000);
      step(1'b1, 1'b0, 3'(o), 4'b1100, 4'b1010);
      checks++; if (bus.y !== expected[o]) begin errors++; $display("[TB] FAIL op_sweep_y[op=%0d] got %b expected %b", o, bus.y, expected[o]); end
    end
    step(1'b0, 1'b1, 3'd0, 4'b0000, 4'b0000);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL op_sweep_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_op_latch();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, (i < 3) ? 3'd0 : 3'd7, 4'b1111, 4'b1111);
      checks++; if (bus.y !== 4'b1111) begin errors++; $display("[TB] FAIL latch_y[%0d] got %b expected 1111", i, bus.y); end
    end
    checks++; if (bus.count_valid !== 1'b1) begin errors++; $display("[TB] FAIL latch_count_valid got %b expected 1", bus.count_valid); end
    checks++; if (bus.counts !== 16'h8888) begin errors++; $display("[TB] FAIL latch_counts got %h expected 8888", bus.counts); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 3'd7, 4'b1111, 4'b1111);
      checks++; if (bus.y !== 4'b0000) begin errors++; $display("[TB] FAIL latch_nor_y[%0d] got %b expected 0000", i, bus.y); end
    end
    checks++; if (bus.count_valid !== 1'b1) begin errors++; $display("[TB] FAIL latch_nor_count_valid got %b expected 1", bus.count_valid); end
    checks++; if (bus.counts !== 16'h0000) begin errors++; $display("[TB] FAIL latch_nor_counts got %h expected 0000", bus.counts); end
  endtask

  task automatic test_toggle();
    logic v;
    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0);
      step(v, 1'b0, 3'd1, 4'b0011, 4'b0000);
      checks++; if (bus.out_valid !== v) begin errors++; $display("[TB] FAIL toggle_out_valid[%0d] got %b expected %b", i, bus.out_valid, v); end
      checks++; if (bus.count_valid !== (i == 14)) begin errors++; $display("[TB] FAIL toggle_count_valid[%0d] got %b expected %b", i, bus.count_valid, (i == 14)); end
    end
    checks++; if (bus.counts !== 16'h0088) begin errors++; $display("[TB] FAIL toggle_counts got %h expected 0088", bus.counts); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 3'd0, 4'b1111, 4'b1111);
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_busy_before got %b expected 1", bus.busy); end
    step(1'b1, 1'b1, 3'd0, 4'b1111, 4'b1111);
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_count_valid got %b expected 0", bus.count_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy_after got %b expected 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.counts !== 16'h0088) begin errors++; $display("[TB] FAIL clear_counts_hold got %h expected 0088", bus.counts); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 3'd0, 4'b0001, 4'b1111);
      checks++; if (bus.count_valid !== (i == 7)) begin errors++; $display("[TB] FAIL clear_new_count_valid[%0d] got %b expected %b", i, bus.count_valid, (i == 7)); end
    end
    checks++; if (bus.y !== 4'b0001) begin errors++; $display("[TB] FAIL clear_new_y got %b expected 0001", bus.y); end
    checks++; if (bus.counts !== 16'h0008) begin errors++; $display("[TB] FAIL clear_new_counts got %h expected 0008", bus.counts); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'd0, 4'b1111, 4'b1111);
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL areset_busy_before got %b expected 1", bus.busy); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.y !== 4'b0000) begin errors++; $display("[TB] FAIL areset_y got %b expected 0000", bus.y); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.counts !== 16'h0000) begin errors++; $display("[TB] FAIL areset_counts got %h expected 0000", bus.counts); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got %b expected 0", bus.busy); end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 3'd0, 4'b1111, 4'b1111);
      checks++; if (bus.count_valid !== (i == 7)) begin errors++; $display("[TB] FAIL areset_count_valid[%0d] got %b expected %b", i, bus.count_valid, (i == 7)); end
    end
    checks++; if (bus.counts !== 16'h8888) begin errors++; $display("[TB] FAIL areset_counts_after got %h expected 8888", bus.counts); end
  endtask

  // ORNOT with a=0, b=0101 yields 1010 every sample
  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 3'd3, 4'b0000, 4'b0101);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_valid[%0d] got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.count_valid !== (i % 8 == 7)) begin errors++; $display("[TB] FAIL b2b_count_valid[%0d] got %b expected %b", i, bus.count_valid, (i % 8 == 7)); end
      if (i % 8 == 7) begin
        checks++; if (bus.counts !== 16'h8080) begin errors++; $display("[TB] FAIL b2b_counts[%0d] got %h expected 8080", i, bus.counts); end
      end
    end
    step(1'b0, 1'b0, 3'd3, 4'b0000, 4'b0101);
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_count_valid got %b expected 0", bus.count_valid); end
  endtask

  // run every scenario in order, then report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_andnot();
    test_op_sweep();
    test_op_latch();
    test_toggle();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
